sum_acc: RTL and testbench

- Downstream consumer of the two-stage 4-operand adder.
- Tracks operand validity alongside the adder's fixed pipeline latency, because the adder carries no valid.
- Accumulates ACC_LEN adder results into one widened group total.
- Presents each total on a registered valid/ready output.
- No backpressure reaches the adder: a group that cannot be delivered is dropped and flagged.

---
 rtl/sum_acc_pkg.sv | 24 ++
 rtl/sum_acc_vld_dly.sv | 31 +++
 rtl/sum_acc.sv | 147 ++++++++++++++
 tb/tb_sum_acc.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_acc_pkg.sv
// Shared definitions for the sum_acc group accumulator: default adder latency,
// FSM state encoding and a constant-foldable ceil(log2) helper.
package sum_acc_pkg;

    localparam int ADD_LAT_DEF = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res++;
            v = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sum_acc_vld_dly.sv
// Operand-valid delay line matching the adder's fixed latency; its output
// marks the cycles in which the adder result is meaningful.
module sum_acc_vld_dly
    import sum_acc_pkg::*;
#(
    parameter int DEPTH = ADD_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] pipe;

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its neighbour's pre-edge value; blocking here would collapse the shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/sum_acc.sv
// Group accumulator behind a two-stage 4-operand adder: sums ACC_LEN results
// into a widened total on a valid/ready output. Optional macro SUM_ACC_SAT_EN.
module sum_acc
    import sum_acc_pkg::*;
#(
    parameter int DSIZE   = 64,
    parameter int ACC_LEN = 8,
    parameter int ADD_LAT = ADD_LAT_DEF,
    localparam int ASIZE  = DSIZE + clog2(ACC_LEN),
    localparam int CNT_W  = clog2(ACC_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_vld,
    input  logic [DSIZE-1:0] sum,
    input  logic             flush,
    output logic [ASIZE-1:0] acc_data,
    output logic [CNT_W-1:0] acc_cnt,
    output logic             acc_vld,
    input  logic             acc_rdy,
    output logic             ovf_err
`ifdef SUM_ACC_SAT_EN
    ,
    output logic             acc_sat
`endif
);

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(ACC_LEN);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t           state, state_nxt;
    logic [ASIZE-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [ASIZE-1:0] sum_ext, acc_sum, emit_total, out_data;
    logic [CNT_W-1:0] emit_cnt;
    logic             res_vld;
    logic             emit;

    sum_acc_vld_dly #(.DEPTH(ADD_LAT)) u_vld_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (op_vld),
        .dout (res_vld)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        sum_ext    = ASIZE'(sum);
        acc_sum    = acc + sum_ext;
        cnt_inc    = cnt + ONE_C;
        state_nxt  = state;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        emit       = 1'b0;
        emit_total = acc_sum;
        emit_cnt   = cnt_inc;
        case (state)
            IDLE: begin
                if (res_vld) begin
                    if (flush) begin
                        emit       = 1'b1;
                        emit_total = sum_ext;
                        emit_cnt   = ONE_C;
                    end else begin
                        acc_nxt   = sum_ext;
                        cnt_nxt   = ONE_C;
                        state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (res_vld) begin
                    if (cnt_inc == LEN_C || flush) begin
                        emit      = 1'b1;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        acc_nxt = acc_sum;
                        cnt_nxt = cnt_inc;
                    end
                end else if (flush) begin
                    // Flush with no new result emits what has been gathered so far.
                    emit       = 1'b1;
                    emit_total = acc;
                    emit_cnt   = cnt;
                    acc_nxt    = '0;
                    cnt_nxt    = '0;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SUM_ACC_SAT_EN
    localparam logic [ASIZE-1:0] DMAX = ASIZE'({DSIZE{1'b1}});
    logic clamp;
    assign clamp    = |emit_total[ASIZE-1:DSIZE];
    assign out_data = clamp ? DMAX : emit_total;
`else
    assign out_data = emit_total;
`endif

    // NOTE: reset is synchronous and covers all state, including the datapath
    // registers, so a restarted accumulator never sees a stale partial total.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The adder cannot be stalled: an emit that finds the output occupied is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_data <= '0;
            acc_cnt  <= '0;
            acc_vld  <= 1'b0;
            ovf_err  <= 1'b0;
`ifdef SUM_ACC_SAT_EN
            acc_sat  <= 1'b0;
`endif
        end else begin
            if (emit && (!acc_vld || acc_rdy)) begin
                acc_data <= out_data;
                acc_cnt  <= emit_cnt;
                acc_vld  <= 1'b1;
`ifdef SUM_ACC_SAT_EN
                acc_sat  <= clamp;
`endif
            end else if (acc_vld && acc_rdy) begin
                acc_vld <= 1'b0;
            end
            if (emit && acc_vld && !acc_rdy) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sum_acc.sv
// Directed self-checking bench for sum_acc (DSIZE=64, ACC_LEN=4, ADD_LAT=2);
// a two-register adder model feeds `sum` with garbage on idle cycles.
module tb_sum_acc;

    localparam int DSIZE   = 64;
    localparam int ACC_LEN = 4;
    localparam int ADD_LAT = 2;
    localparam int ASIZE   = 66;
    localparam int CNT_W   = 3;

    logic             clk;
    logic             rst;
    logic             op_vld;
    logic [DSIZE-1:0] a_val;
    logic [DSIZE-1:0] add_d1;
    logic [DSIZE-1:0] sum;
    logic             flush;
    logic [ASIZE-1:0] acc_data;
    logic [CNT_W-1:0] acc_cnt;
    logic             acc_vld;
    logic             acc_rdy;
    logic             ovf_err;
`ifdef SUM_ACC_SAT_EN
    logic             acc_sat;
`endif

    int n_chk;
    int n_pass;

    sum_acc #(
        .DSIZE   (DSIZE),
        .ACC_LEN (ACC_LEN),
        .ADD_LAT (ADD_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .op_vld   (op_vld),
        .sum      (sum),
        .flush    (flush),
        .acc_data (acc_data),
        .acc_cnt  (acc_cnt),
        .acc_vld  (acc_vld),
        .acc_rdy  (acc_rdy),
        .ovf_err  (ovf_err)
`ifdef SUM_ACC_SAT_EN
        ,
        .acc_sat  (acc_sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage adder stand-in: result appears two cycles after op_vld, garbage otherwise.
    always @(posedge clk) begin
        add_d1 <= op_vld ? a_val : {$urandom, $urandom};
        sum    <= add_d1;
    end

    // Drive one cycle of inputs, then advance to just after the closing edge.
    task automatic step(input logic ov, input logic [DSIZE-1:0] v, input logic fl);
        op_vld = ov;
        a_val  = v;
        flush  = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        acc_rdy = 1'b1;
        idle(3);
        n_chk++; if (acc_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", acc_vld); else n_pass++;
        n_chk++; if (acc_data !== '0) $display("FAIL reset_data: got %0h want 0", acc_data); else n_pass++;
        n_chk++; if (acc_cnt !== '0) $display("FAIL reset_cnt: got %0d want 0", acc_cnt); else n_pass++;
        n_chk++; if (ovf_err !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf_err); else n_pass++;
`ifdef SUM_ACC_SAT_EN
        n_chk++; if (acc_sat !== 1'b0) $display("FAIL reset_sat: got %b want 0", acc_sat); else n_pass++;
`endif
        rst = 1'b0;
        idle(2);
        n_chk++; if (acc_vld !== 1'b0) $display("FAIL reset_idle_vld: got %b want 0", acc_vld); else n_pass++;
    endtask

    task automatic test_basic;
        acc_rdy = 1'b1;
        step(1'b1, 64'd1, 1'b0);
        step(1'b1, 64'd2, 1'b0);
        step(1'b1, 64'd3, 1'b0);
        step(1'b1, 64'd4, 1'b0);
        step(1'b0, '0, 1'b0);
        n_chk++; if (acc_vld !== 1'b0) $display("FAIL basic_early: got %b want 0", acc_vld); else n_pass++;
        step(1'b0, '0, 1'b0);
        n_chk++; if (acc_vld !== 1'b1) $display("FAIL basic_vld: got %b want 1", acc_vld); else n_pass++;
        n_chk++; if (acc_data !== 66'd10) $display("FAIL basic_data: got %0d want 10", acc_data); else n_pass++;
        n_chk++; if (acc_cnt !== 3'd4) $display("FAIL basic_cnt: got %0d want 4", acc_cnt); else n_pass++;
`ifdef SUM_ACC_SAT_EN
        n_chk++; if (acc_sat !== 1'b0) $display("FAIL basic_sat: got %b want 0", acc_sat); else n_pass++;
`endif
        step(1'b0, '0, 1'b0);
        n_chk++; if (acc_vld !== 1'b0) $display("FAIL basic_one_cycle: got %b want 0", acc_vld); else n_pass++;
    endtask

    task automatic test_max;
        acc_rdy = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        idle(2);
        n_chk++; if (acc_vld !== 1'b1) $display("FAIL max_vld: got %b want 1", acc_vld); else n_pass++;
`ifdef SUM_ACC_SAT_EN
        n_chk++; if (acc_data !== 66'h0_FFFF_FFFF_FFFF_FFFF)
            $display("FAIL max_data: got %0h want ffffffffffffffff", acc_data); else n_pass++;
        n_chk++; if (acc_sat !== 1'b1) $display("FAIL max_sat: got %b want 1", acc_sat); else n_pass++;
`else
        n_chk++; if (acc_data !== 66'h3_FFFF_FFFF_FFFF_FFFC)
            $display("FAIL max_data: got %0h want 3fffffffffffffffc", acc_data); else n_pass++;
`endif
        idle(1);
    endtask

    task automatic test_flush;
        acc_rdy = 1'b1;
        // 5 then 7, flush aligned with the result of 7
        step(1'b1, 64'd5, 1'b0);
        step(1'b1, 64'd7, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        n_chk++; if (acc_vld !== 1'b1) $display("FAIL flush2_vld: got %b want 1", acc_vld); else n_pass++;
        n_chk++; if (acc_data !== 66'd12) $display("FAIL flush2_data: got %0d want 12", acc_data); else n_pass++;
        n_chk++; if (acc_cnt !== 3'd2) $display("FAIL flush2_cnt: got %0d want 2", acc_cnt); else n_pass++;
        idle(1);
        // flush alone in IDLE
        step(1'b0, '0, 1'b1);
        n_chk++; if (acc_vld !== 1'b0) $display("FAIL flush_idle_vld: got %b want 0", acc_vld); else n_pass++;
        idle(1);
        n_chk++; if (acc_vld !== 1'b0) $display("FAIL flush_idle_vld2: got %b want 0", acc_vld); else n_pass++;
        // flush in IDLE alongside result 9
        step(1'b1, 64'd9, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        n_chk++; if (acc_vld !== 1'b1) $display("FAIL flush1_vld: got %b want 1", acc_vld); else n_pass++;
        n_chk++; if (acc_data !== 66'd9) $display("FAIL flush1_data: got %0d want 9", acc_data); else n_pass++;
        n_chk++; if (acc_cnt !== 3'd1) $display("FAIL flush1_cnt: got %0d want 1", acc_cnt); else n_pass++;
        idle(1);
        // flush in ACCUM with no result that cycle emits the partial total
        step(1'b1, 64'd3, 1'b0);
        idle(2);
        step(1'b0, '0, 1'b1);
        n_chk++; if (acc_vld !== 1'b1) $display("FAIL flush_acc_vld: got %b want 1", acc_vld); else n_pass++;
        n_chk++; if (acc_data !== 66'd3) $display("FAIL flush_acc_data: got %0d want 3", acc_data); else n_pass++;
        n_chk++; if (acc_cnt !== 3'd1) $display("FAIL flush_acc_cnt: got %0d want 1", acc_cnt); else n_pass++;
        idle(1);
        n_chk++; if (acc_vld !== 1'b0) $display("FAIL flush_acc_done: got %b want 0", acc_vld); else n_pass++;
    endtask

    task automatic test_gapped;
        acc_rdy = 1'b1;
        step(1'b1, 64'd1, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, 64'd2, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, 64'd3, 1'b0);
        step(1'b1, 64'd4, 1'b0);
        step(1'b0, '0, 1'b0);
        n_chk++; if (acc_vld !== 1'b0) $display("FAIL gap_early: got %b want 0", acc_vld); else n_pass++;
        step(1'b0, '0, 1'b0);
        n_chk++; if (acc_vld !== 1'b1) $display("FAIL gap_vld: got %b want 1", acc_vld); else n_pass++;
        n_chk++; if (acc_data !== 66'd10) $display("FAIL gap_data: got %0d want 10", acc_data); else n_pass++;
        n_chk++; if (acc_cnt !== 3'd4) $display("FAIL gap_cnt: got %0d want 4", acc_cnt); else n_pass++;
        idle(1);
    endtask

    task automatic test_back_to_back;
        acc_rdy = 1'b0;
        // groups 1..4 (10) and 5..8 (26) with the sink stalled
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 64'(i), 1'b0);
            if (i == 6) begin
                n_chk++; if (acc_vld !== 1'b1 || acc_data !== 66'd10)
                    $display("FAIL bp_first: got vld=%b data=%0d want vld=1 data=10", acc_vld, acc_data); else n_pass++;
                n_chk++; if (ovf_err !== 1'b0) $display("FAIL bp_ovf_early: got %b want 0", ovf_err); else n_pass++;
            end
        end
        idle(2);
        n_chk++; if (acc_data !== 66'd10) $display("FAIL bp_hold_data: got %0d want 10", acc_data); else n_pass++;
        n_chk++; if (acc_cnt !== 3'd4) $display("FAIL bp_hold_cnt: got %0d want 4", acc_cnt); else n_pass++;
        n_chk++; if (ovf_err !== 1'b1) $display("FAIL bp_ovf: got %b want 1", ovf_err); else n_pass++;
        idle(1);
        n_chk++; if (ovf_err !== 1'b1) $display("FAIL bp_ovf_sticky: got %b want 1", ovf_err); else n_pass++;
        // group 2,2,2,2 whose emit coincides with the sink accepting the held 10
        for (int i = 0; i < 4; i++) step(1'b1, 64'd2, 1'b0);
        step(1'b0, '0, 1'b0);
        n_chk++; if (acc_vld !== 1'b1 || acc_data !== 66'd10)
            $display("FAIL b2b_hold: got vld=%b data=%0d want vld=1 data=10", acc_vld, acc_data); else n_pass++;
        acc_rdy = 1'b1;
        step(1'b0, '0, 1'b0);
        n_chk++; if (acc_vld !== 1'b1) $display("FAIL b2b_vld: got %b want 1", acc_vld); else n_pass++;
        n_chk++; if (acc_data !== 66'd8) $display("FAIL b2b_data: got %0d want 8", acc_data); else n_pass++;
        step(1'b0, '0, 1'b0);
        n_chk++; if (acc_vld !== 1'b0) $display("FAIL b2b_drain: got %b want 0", acc_vld); else n_pass++;
        n_chk++; if (ovf_err !== 1'b1) $display("FAIL b2b_ovf_sticky: got %b want 1", ovf_err); else n_pass++;
    endtask

    task automatic test_reset_mid;
        acc_rdy = 1'b1;
        step(1'b1, 64'd1, 1'b0);
        step(1'b1, 64'd2, 1'b0);
        step(1'b1, 64'd3, 1'b0);
        step(1'b0, '0, 1'b0);
        // result 3 is on the adder output while reset is applied
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        rst = 1'b0;
        n_chk++; if (acc_vld !== 1'b0) $display("FAIL rmid_vld: got %b want 0", acc_vld); else n_pass++;
        n_chk++; if (acc_data !== '0) $display("FAIL rmid_data: got %0d want 0", acc_data); else n_pass++;
        n_chk++; if (acc_cnt !== '0) $display("FAIL rmid_cnt: got %0d want 0", acc_cnt); else n_pass++;
        n_chk++; if (ovf_err !== 1'b0) $display("FAIL rmid_ovf: got %b want 0", ovf_err); else n_pass++;
        for (int i = 0; i < 4; i++) step(1'b1, 64'd1, 1'b0);
        step(1'b0, '0, 1'b0);
        n_chk++; if (acc_vld !== 1'b0) $display("FAIL rmid_early: got %b want 0", acc_vld); else n_pass++;
        step(1'b0, '0, 1'b0);
        n_chk++; if (acc_vld !== 1'b1) $display("FAIL rmid_after_vld: got %b want 1", acc_vld); else n_pass++;
        n_chk++; if (acc_data !== 66'd4) $display("FAIL rmid_after_data: got %0d want 4", acc_data); else n_pass++;
        n_chk++; if (acc_cnt !== 3'd4) $display("FAIL rmid_after_cnt: got %0d want 4", acc_cnt); else n_pass++;
        idle(1);
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rst     = 1'b1;
        op_vld  = 1'b0;
        a_val   = '0;
        flush   = 1'b0;
        acc_rdy = 1'b1;
        test_reset;
        test_basic;
        test_max;
        test_flush;
        test_gapped;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
